// File: rtl/la_gcd_pkg.sv
// rtl/la_gcd_pkg.sv - shared types and LA bit map for the GCD accelerator
package la_gcd_pkg;

  localparam int GCD_WIDTH = 32;
  localparam int K_W       = 6;

  localparam int LA_A_LSB  = 0;
  localparam int LA_B_LSB  = 32;
  localparam int LA_START  = 64;
  localparam int LA_BUSY   = 32;
  localparam int LA_DONE   = 33;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } gcd_state_e;

endpackage

// File: rtl/la_gcd_core.sv
// rtl/la_gcd_core.sv - binary (Stein) GCD engine with start/busy/done handshake
module gcd_core
  import la_gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  gcd_state_e       state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [K_W-1:0]   k;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a      <= '0;
      b      <= '0;
      k      <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a     <= a_in;
            b     <= b_in;
            k     <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          // k tracks the common power of two factored out; it is restored on exit
          if (a == '0) begin
            result <= b << k;
            state  <= DONE;
          end else if (b == '0) begin
            result <= a << k;
            state  <= DONE;
          end else if (a == b) begin
            result <= a << k;
            state  <= DONE;
          end else if (!a[0] && !b[0]) begin
            a <= a >> 1;
            b <= b >> 1;
            k <= k + 1'b1;
          end else if (!a[0]) begin
            a <= a >> 1;
          end else if (!b[0]) begin
            b <= b >> 1;
          end else if (a > b) begin
            a <= a - b;
          end else begin
            b <= b - a;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: rtl/la_gcd_accel.sv
// rtl/la_gcd_accel.sv - logic-analyzer register wrapper around the GCD engine
module la_gcd_accel
  import la_gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic [127:0] la_data_in,
  input  logic [127:0] la_oenb,
  output logic [127:0] la_data_out
);

  logic             start;
  logic             start_q;
  logic             launch;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             unused_la;

  // start only counts when firmware actually drives the bit
  assign start  = la_data_in[LA_START] & ~la_oenb[LA_START];
  assign launch = start & ~start_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      start_q <= 1'b0;
    end else begin
      start_q <= start;
    end
  end

  gcd_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .start  (launch),
    .a_in   (la_data_in[LA_A_LSB +: WIDTH]),
    .b_in   (la_data_in[LA_B_LSB +: WIDTH]),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always_comb begin
    la_data_out                       = '0;
    la_data_out[LA_A_LSB +: WIDTH]    = result;
    la_data_out[LA_BUSY]              = busy;
    la_data_out[LA_DONE]              = done;
  end

  assign unused_la = ^{la_data_in[127:65], la_oenb[127:65], la_oenb[63:0]};

endmodule

// File: tb/tb_la_gcd_accel.sv
// tb/tb_la_gcd_accel.sv - scoreboard bench for la_gcd_accel
module tb_la_gcd_accel;

  logic         wb_clk_i;
  logic         wb_rst_i;
  logic [127:0] la_data_in;
  logic [127:0] la_oenb;
  logic [127:0] la_data_out;

  int total;
  int bad;
  int done_rises;
  logic done_q;
  logic [31:0] exp_q[$];

  la_gcd_accel dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .la_data_in  (la_data_in),
    .la_oenb     (la_oenb),
    .la_data_out (la_data_out)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  wire [31:0] res  = la_data_out[31:0];
  wire        busy = la_data_out[32];
  wire        done = la_data_out[33];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // monitor: every rising done pops one expected result
  initial begin
    done_q = 1'b0;
    done_rises = 0;
    forever begin
      @(negedge wb_clk_i);
      if (done && !done_q) begin
        done_rises++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 128'd1, 128'd0);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          check("result", {96'd0, res}, {96'd0, e});
          check("upper_zero", {34'd0, la_data_out[127:34]}, 128'd0);
        end
      end
      done_q = done;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge wb_clk_i);
      #1;
    end
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b, input bit expect_done,
                        input logic [31:0] e);
    la_data_in[31:0]  = a;
    la_data_in[63:32] = b;
    la_data_in[64]    = 1'b1;
    la_oenb[64]       = 1'b0;
    if (expect_done) exp_q.push_back(e);
    tick(1);
    check("launch_busy_done", {126'd0, busy, done}, {126'd0, 2'b10});
    la_data_in[64] = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 200) begin
      tick(1);
      cyc++;
    end
    if (!done) check("done_timeout", 128'd0, 128'd1);
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    int cyc;
    launch(a, b, 1'b1, e);
    wait_done(cyc);
    tick(2);
  endtask

  initial begin
    int cyc;
    int rises0;
    total = 0;
    bad   = 0;
    wb_rst_i   = 1'b1;
    la_data_in = '0;
    la_oenb    = '1;
    tick(3);
    check("reset_out", la_data_out, 128'd0);
    wb_rst_i = 1'b0;
    tick(2);

    launch(32'd10312050, 32'd29460792, 1'b1, 32'd138);
    wait_done(cyc);
    check("latency_le_130", {127'd0, (cyc <= 130)}, 128'd1);
    tick(2);

    run(32'd1993627629, 32'd1177417612, 32'd7);
    run(32'd2097015289, 32'd3812041926, 32'd1);
    run(32'd1924134885, 32'd3151131255, 32'd135);
    run(32'd992211318,  32'd512609597,  32'd1);
    run(32'd0, 32'd0, 32'd0);
    run(32'd0, 32'd42, 32'd42);
    run(32'd42, 32'd0, 32'd42);
    run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run(32'h8000_0000, 32'h4000_0000, 32'h4000_0000);

    // start held high for 200 cycles -> single computation
    rises0 = done_rises;
    la_data_in[31:0]  = 32'd91;
    la_data_in[63:32] = 32'd35;
    la_data_in[64]    = 1'b1;
    la_oenb[64]       = 1'b0;
    exp_q.push_back(32'd7);
    tick(200);
    la_data_in[64] = 1'b0;
    tick(3);
    check("held_start_once", done_rises - rises0, 1);

    // start pulse mid-RUN is ignored
    rises0 = done_rises;
    launch(32'd2097015289, 32'd3812041926, 1'b1, 32'd1);
    tick(2);
    check("midrun_busy", {127'd0, busy}, 128'd1);
    la_data_in[31:0]  = 32'd0;
    la_data_in[63:32] = 32'd5;
    la_data_in[64]    = 1'b1;
    tick(1);
    la_data_in[64] = 1'b0;
    wait_done(cyc);
    tick(5);
    check("midrun_single_done", done_rises - rises0, 1);
    check("midrun_result_held", {96'd0, res}, 128'd1);

    // firmware not driving start bit -> no launch
    la_data_in[31:0]  = 32'd12;
    la_data_in[63:32] = 32'd18;
    la_data_in[64]    = 1'b1;
    la_oenb[64]       = 1'b1;
    tick(4);
    check("oenb_no_launch", {126'd0, busy, done}, {126'd0, 2'b01});
    la_data_in[64] = 1'b0;
    la_oenb[64]    = 1'b0;
    tick(1);

    // reset mid-RUN aborts without a done
    rises0 = done_rises;
    launch(32'd2097015289, 32'd3812041926, 1'b0, 32'd0);
    tick(4);
    wb_rst_i = 1'b1;
    tick(1);
    check("rst_midrun_out", la_data_out, 128'd0);
    wb_rst_i = 1'b0;
    tick(150);
    check("rst_no_done", done_rises - rises0, 0);
    check("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
